// File: rtl/hit_judge.sv
// Reaction-game judge: arms a response window per accepted target and emits one
// registered hit or miss pulse per target, followed by a release-gated cooldown.
module hit_judge #(
    parameter int N_BTN         = 4,
    parameter int WINDOW_CYCLES = 1000,
    parameter int COOL_CYCLES   = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             target_valid,
    input  logic [$clog2(N_BTN)-1:0]         target_id,
    output logic                             target_ready,
    input  logic [N_BTN-1:0]                 btn,
    output logic                             hit_pulse,
    output logic                             miss_pulse,
    output logic [$clog2(WINDOW_CYCLES)-1:0] reaction_cycles,
    output logic                             busy
);
    localparam int TID_W = $clog2(N_BTN);
    localparam int TMR_W = $clog2(WINDOW_CYCLES);
    localparam int CNT_W = (COOL_CYCLES > 1) ? $clog2(COOL_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COOL_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_COOLDOWN
    } state_t;

    state_t           r_state, w_state_next;
    logic [TMR_W-1:0] r_timer, w_timer_next;
    logic [CNT_W-1:0] r_cool, w_cool_next;
    logic [TID_W-1:0] r_target, w_target_next;
    logic [TMR_W-1:0] r_react, w_react_next;
    logic             r_hit, w_hit_next;
    logic             r_miss, w_miss_next;
    logic [N_BTN-1:0] r_btn_prev;
    logic [N_BTN-1:0] w_press_edge;
    logic [N_BTN-1:0] w_onehot;
    logic             w_any_edge;

    // An out-of-range target decodes to all zeros, so no press can ever match it.
    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi++) begin : g_onehot
            assign w_onehot[gi] = (r_target == TID_W'(gi));
        end
    endgenerate

    assign w_press_edge = btn & ~r_btn_prev;
    assign w_any_edge   = |w_press_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_cool     <= '0;
            r_target   <= '0;
            r_react    <= '0;
            r_hit      <= 1'b0;
            r_miss     <= 1'b0;
            r_btn_prev <= '0;
        end else begin
            r_state    <= w_state_next;
            r_timer    <= w_timer_next;
            r_cool     <= w_cool_next;
            r_target   <= w_target_next;
            r_react    <= w_react_next;
            r_hit      <= w_hit_next;
            r_miss     <= w_miss_next;
            r_btn_prev <= btn;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_timer_next  = r_timer;
        w_cool_next   = r_cool;
        w_target_next = r_target;
        w_react_next  = r_react;
        w_hit_next    = 1'b0;
        w_miss_next   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (target_valid) begin
                    w_target_next = target_id;
                    w_timer_next  = '0;
                    w_cool_next   = '0;
                    w_state_next  = S_ARMED;
                end
            end
            S_ARMED: begin
                w_timer_next = r_timer + 1'b1;
                // A press on the final window edge wins over the timeout.
                if (w_any_edge) begin
                    if (w_press_edge == w_onehot) begin
                        w_hit_next   = 1'b1;
                        w_react_next = r_timer;
                    end else begin
                        w_miss_next = 1'b1;
                    end
                    w_cool_next  = '0;
                    w_state_next = S_COOLDOWN;
                end else if (r_timer == TMR_LAST) begin
                    w_miss_next  = 1'b1;
                    w_cool_next  = '0;
                    w_state_next = S_COOLDOWN;
                end
            end
            S_COOLDOWN: begin
                if (|btn) begin
                    w_cool_next = '0;
                end else if (r_cool == CNT_LAST) begin
                    w_cool_next  = '0;
                    w_state_next = S_IDLE;
                end else begin
                    w_cool_next = r_cool + 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign target_ready    = (r_state == S_IDLE);
    assign busy            = (r_state != S_IDLE);
    assign hit_pulse       = r_hit;
    assign miss_pulse      = r_miss;
    assign reaction_cycles = r_react;
endmodule

// File: doc/hit_judge.md
Name: hit_judge

Overview:
- Upstream stage of the score updater. Accepts a target (which button the player must press) and arms a timed response window. Judges the player's button presses.
- Produces the single-cycle, mutually exclusive hit_pulse / miss_pulse that the score updater consumes. Also reports reaction time for each hit.
- A cooldown phase ensures one target yields exactly one judgement.

Parameters:
- N_BTN, 4, number of player buttons (2..16).
- WINDOW_CYCLES, 1000, clock cycles the player has to respond after a target is accepted (>=2).
- COOL_CYCLES, 16, minimum cycles spent in cooldown after a judgement, once all buttons are released (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- target_valid  in  1  new target offered.
- target_id  in  $clog2(N_BTN)  index of the button the player must press; sampled when accepted.
- target_ready  out  1  block can accept a target (high only in IDLE).
- btn  in  N_BTN  button levels; already synchronised and debounced; 1 = pressed.
- hit_pulse  out  1  one-cycle pulse: correct press inside the window.
- miss_pulse  out  1  one-cycle pulse: wrong press or timeout.
- reaction_cycles  out  $clog2(WINDOW_CYCLES)  timer value captured at the last hit.
- busy  out  1  high in ARMED or COOLDOWN.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE. Timer, cooldown counter, btn_prev and stored target all clear to 0.
  - hit_pulse=0, miss_pulse=0, reaction_cycles=0, busy=0, target_ready=1.
  - Reset asserted mid-round abandons the round with no pulse emitted.
- Edge detection:
  - btn_prev registers btn every cycle in all states.
  - press_edge = btn & ~btn_prev.
  - A button already held when a target is accepted produces no edge until it is released and pressed again.
- Handshake: a target is accepted on a rising edge where target_valid && target_ready.
  - target_id is latched and the timer is loaded to 0.
  - State goes to ARMED on the next cycle.
  - target_valid is ignored while target_ready=0; there is no queueing.
- IDLE: presses are ignored (no pulses). Transitions to ARMED on accept.
- ARMED: each cycle the timer increments by 1. Judgement on each edge, in priority order:
  1. press_edge != 0 and press_edge == one-hot(target_id):
     - hit_pulse=1 next cycle.
     - reaction_cycles <= timer value at that edge.
     - State goes to COOLDOWN.
  2. press_edge != 0 otherwise (wrong button, or correct plus any other button on the same edge):
     - miss_pulse=1 next cycle; state goes to COOLDOWN.
  3. No edge and timer == WINDOW_CYCLES-1:
     - miss_pulse=1 next cycle; state goes to COOLDOWN.
- Simultaneous press and timeout on the same edge: the press is judged; timeout does not apply.
- The window therefore spans exactly WINDOW_CYCLES sampling edges, timer values 0..WINDOW_CYCLES-1.
- An out-of-range target_id (possible when N_BTN is not a power of two) can never hit: any press is a miss, otherwise timeout is a miss.
- Pulses are registered outputs, high for exactly one cycle, never both high, at most one per accepted target.
- COOLDOWN:
  - The cooldown counter holds at 0 while any btn bit is high.
  - Once btn == 0 the counter increments each cycle.
  - When it reaches COOL_CYCLES-1, the counter clears and state goes to IDLE.
  - A press during cooldown resets the counter to 0.
  - No pulses are generated in COOLDOWN.
- reaction_cycles holds its value until the next hit. Misses do not change it.
- busy = (state != IDLE). target_ready = (state == IDLE). Both are decoded directly from the state register.

Test Plan (WINDOW_CYCLES=20, COOL_CYCLES=4, N_BTN=4):
- Reset, offer target_id=2, press btn=4'b0100 at timer=7 -> exactly one hit_pulse; reaction_cycles=7; busy stays high until 4 cycles after btn returns to 0, then target_ready=1.
- Offer target_id=1, never press -> miss_pulse exactly 20 cycles after the ARMED entry edge; no hit_pulse.
- Offer target_id=0, press btn=4'b0011 on one edge -> miss_pulse; reaction_cycles unchanged from its previous value.
- Hold btn[3] high, offer target_id=3 with btn[3] still held -> no hit; release then re-press at timer=5 -> hit_pulse, reaction_cycles=5.
- Press the correct button on the edge where timer=19 -> hit_pulse only; no miss_pulse in any cycle.
- Assert rst_n=0 mid-ARMED, then release -> no pulses; target_ready=1; reaction_cycles=0; a new target is accepted normally. Also check target_valid during COOLDOWN is ignored (no second judgement).
